// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch redirect path.
// Pipeline records carried from D through E to M.
package bpu_pkg;

    localparam int DEF_PC_W         = 32;
    localparam int DEF_FALLTHRU_OFS = 8;
    localparam int INSN_BYTES       = 4;

    typedef struct packed {
        logic                valid;
        logic                pred_take;
        logic [DEF_PC_W-1:0] target;
        logic [DEF_PC_W-1:0] fallthru;
    } pipe_rec_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Next-PC select and misprediction recovery.
// Carries each branch's prediction and both successors D->E->M.
module branch_redirect_unit
    import bpu_pkg::*;
#(
    parameter int PC_W         = DEF_PC_W,
    parameter int FALLTHRU_OFS = DEF_FALLTHRU_OFS,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             stallM,
    input  logic             flushM,
    input  logic [PC_W-1:0]  pcF,
    input  logic [PC_W-1:0]  pcD,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [PC_W-1:0]  targetD,
    input  logic             branchM,
    input  logic             actual_takeM,
    output logic [PC_W-1:0]  pc_next,
    output logic             mispredM,
    output logic             pred_takeM,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    pipe_rec_t rec_d;
    pipe_rec_t rec_e;
    pipe_rec_t rec_m;

    logic [PC_W-1:0] recovery_pc;
    logic [PC_W-1:0] seq_pc;
    logic            redirect_d;
    logic            cnt_en;

    always_comb begin
        rec_d           = '0;
        rec_d.valid     = branchD & ~flushD;
        rec_d.pred_take = pred_takeD;
        rec_d.target    = targetD;
        rec_d.fallthru  = pcD + PC_W'(FALLTHRU_OFS);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rec_e <= '0;
        end else if (flushE) begin
            rec_e <= '0;
        end else if (!stallE) begin
            rec_e <= rec_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rec_m <= '0;
        end else if (flushM) begin
            rec_m <= '0;
        end else if (!stallM) begin
            rec_m <= rec_e;
        end
    end

    assign pred_takeM  = rec_m.pred_take;
    assign mispredM    = branchM & rec_m.valid
                       & (rec_m.pred_take != actual_takeM);
    // A wrong taken guess falls back to the delay-slot successor.
    assign recovery_pc = rec_m.pred_take ? rec_m.fallthru
                                         : rec_m.target;
    assign seq_pc      = pcF + PC_W'(INSN_BYTES);
    assign redirect_d  = branchD & pred_takeD & ~flushD & ~stallD;

    // The older M branch always beats a younger D redirect.
    always_comb begin
        pc_next = seq_pc;
        if (mispredM) begin
            pc_next = recovery_pc;
        end else if (redirect_d) begin
            pc_next = targetD;
        end
    end

    assign cnt_en = rec_m.valid & branchM & ~stallM;

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (cnt_en),
        .count (branch_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mispred_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en    (cnt_en & mispredM),
        .count (mispred_cnt)
    );

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit.
// A 2-bit counter instance covers saturation.
module tb_branch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallD, flushD, stallE, flushE, stallM, flushM;
    logic [31:0] pcF, pcD, targetD;
    logic        branchD, pred_takeD, branchM, actual_takeM;
    logic [31:0] pc_next, branch_cnt, mispred_cnt;
    logic        mispredM, pred_takeM;
    logic [31:0] pc_next2;
    logic        mispredM2, pred_takeM2;
    logic [1:0]  branch_cnt2, mispred_cnt2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    branch_redirect_unit dut (
        .clk(clk), .rst(rst),
        .stallD(stallD), .flushD(flushD),
        .stallE(stallE), .flushE(flushE),
        .stallM(stallM), .flushM(flushM),
        .pcF(pcF), .pcD(pcD), .branchD(branchD),
        .pred_takeD(pred_takeD), .targetD(targetD),
        .branchM(branchM), .actual_takeM(actual_takeM),
        .pc_next(pc_next), .mispredM(mispredM),
        .pred_takeM(pred_takeM),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_redirect_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst),
        .stallD(stallD), .flushD(flushD),
        .stallE(stallE), .flushE(flushE),
        .stallM(stallM), .flushM(flushM),
        .pcF(pcF), .pcD(pcD), .branchD(branchD),
        .pred_takeD(pred_takeD), .targetD(targetD),
        .branchM(branchM), .actual_takeM(actual_takeM),
        .pc_next(pc_next2), .mispredM(mispredM2),
        .pred_takeM(pred_takeM2),
        .branch_cnt(branch_cnt2), .mispred_cnt(mispred_cnt2)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        stallD = 0; flushD = 0; stallE = 0; flushE = 0;
        stallM = 0; flushM = 0;
        branchD = 0; pred_takeD = 0; branchM = 0; actual_takeM = 0;
        pcD = 32'h0; targetD = 32'h0;
    endtask

    task automatic d_branch(input logic [31:0] pc,
                            input logic        pt,
                            input logic [31:0] tgt);
        branchD = 1; pcD = pc; pred_takeD = pt; targetD = tgt;
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        pcF = 32'hBFC0_0000;
        settle();
        chk("reset_pc_next", pc_next, 32'hBFC0_0004);
        chk("reset_mispred", {31'b0, mispredM}, 32'h0);
        chk("reset_predM", {31'b0, pred_takeM}, 32'h0);
        chk("reset_bcnt", branch_cnt, 32'h0);
        chk("reset_mcnt", mispred_cnt, 32'h0);
        cyc();
        rst = 1;
        pcF = 32'h0000_1000;
        cyc();

        // Predicted taken, resolved taken
        d_branch(32'h80, 1, 32'h100);
        settle();
        chk("t1_redirect", pc_next, 32'h100);
        cyc();
        idle_inputs();
        cyc();
        branchM = 1; actual_takeM = 1;
        settle();
        chk("t1_mispred", {31'b0, mispredM}, 32'h0);
        chk("t1_predM", {31'b0, pred_takeM}, 32'h1);
        chk("t1_pc_seq", pc_next, 32'h1004);
        cyc();
        idle_inputs();
        settle();
        chk("t1_bcnt", branch_cnt, 32'd1);
        chk("t1_mcnt", mispred_cnt, 32'd0);

        // Predicted taken, resolved not taken
        d_branch(32'h80, 1, 32'h100);
        cyc();
        idle_inputs();
        cyc();
        branchM = 1; actual_takeM = 0;
        settle();
        chk("t2_mispred", {31'b0, mispredM}, 32'h1);
        chk("t2_recover", pc_next, 32'h88);
        cyc();
        idle_inputs();
        settle();
        chk("t2_bcnt", branch_cnt, 32'd2);
        chk("t2_mcnt", mispred_cnt, 32'd1);

        // Predicted not taken, resolved taken, D redirect loses
        d_branch(32'h40, 0, 32'h200);
        settle();
        chk("t3_no_redirect", pc_next, 32'h1004);
        cyc();
        idle_inputs();
        cyc();
        branchM = 1; actual_takeM = 1;
        d_branch(32'h2C0, 1, 32'h300);
        settle();
        chk("t3_mispred", {31'b0, mispredM}, 32'h1);
        chk("t3_m_wins", pc_next, 32'h200);
        cyc();
        idle_inputs();
        flushE = 1; flushM = 1;
        settle();
        chk("t3_bcnt", branch_cnt, 32'd3);
        chk("t3_mcnt", mispred_cnt, 32'd2);
        cyc();
        idle_inputs();
        branchM = 1; actual_takeM = 1;
        settle();
        chk("t3_squashed", {31'b0, mispredM}, 32'h0);
        cyc();
        idle_inputs();

        // Mispredict held in M for three cycles
        d_branch(32'h80, 1, 32'h100);
        cyc();
        idle_inputs();
        cyc();
        branchM = 1; actual_takeM = 0; stallM = 1; stallE = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_stall_mispred", {31'b0, mispredM}, 32'h1);
            chk("t4_stall_pc", pc_next, 32'h88);
            chk("t4_stall_bcnt", branch_cnt, 32'd3);
            cyc();
        end
        stallM = 0; stallE = 0;
        settle();
        chk("t4_release_mispred", {31'b0, mispredM}, 32'h1);
        cyc();
        idle_inputs();
        settle();
        chk("t4_bcnt", branch_cnt, 32'd4);
        chk("t4_mcnt", mispred_cnt, 32'd3);
        chk("t4_small_mcnt", {30'b0, mispred_cnt2}, 32'd3);

        // flushD blocks the D redirect; flushE drops the record
        d_branch(32'h80, 1, 32'h100);
        flushD = 1;
        settle();
        chk("t5_flushD_pc", pc_next, 32'h1004);
        flushD = 0;
        flushE = 1;
        cyc();
        idle_inputs();
        cyc();
        branchM = 1; actual_takeM = 0;
        settle();
        chk("t5_flushE_mispred", {31'b0, mispredM}, 32'h0);
        chk("t5_flushE_predM", {31'b0, pred_takeM}, 32'h0);
        cyc();
        idle_inputs();
        settle();
        chk("t5_bcnt", branch_cnt, 32'd4);

        // One more mispredict: small counters saturate
        d_branch(32'h500, 0, 32'h600);
        cyc();
        idle_inputs();
        cyc();
        branchM = 1; actual_takeM = 1;
        settle();
        chk("t6_recover", pc_next, 32'h600);
        cyc();
        idle_inputs();
        settle();
        chk("t6_bcnt", branch_cnt, 32'd5);
        chk("t6_mcnt", mispred_cnt, 32'd4);
        chk("t6_small_mcnt_sat", {30'b0, mispred_cnt2}, 32'd3);
        chk("t6_small_bcnt_sat", {30'b0, branch_cnt2}, 32'd3);

        // Reset while a mispredict sits in M
        d_branch(32'h80, 1, 32'h100);
        cyc();
        idle_inputs();
        cyc();
        branchM = 1; actual_takeM = 0;
        settle();
        chk("t7_pre_mispred", {31'b0, mispredM}, 32'h1);
        rst = 0;
        #1;
        chk("t7_rst_mispred", {31'b0, mispredM}, 32'h0);
        chk("t7_rst_predM", {31'b0, pred_takeM}, 32'h0);
        chk("t7_rst_pc", pc_next, 32'h1004);
        chk("t7_rst_bcnt", branch_cnt, 32'h0);
        chk("t7_rst_mcnt", mispred_cnt, 32'h0);
        cyc();
        rst = 1;
        idle_inputs();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
